// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose : 640x480@60 Hz VGA raster generator. Free-running pixel/line
//           counters for the pixel sources, and sync/blank strobes that are
//           delayed to line up with RGB coming out of registered-ROM paths.
//
// Ports   :
//   vga_clk      in   pixel clock (single clock domain)
//   reset_n      in   asynchronous, active-low reset
//   hcount       out  [9:0] horizontal position, 0..H_TOTAL-1 (undelayed)
//   vcount       out  [9:0] vertical position, 0..V_TOTAL-1 (undelayed)
//   active       out  high inside the visible area (undelayed)
//   frame_start  out  high while (hcount,vcount) = (0,0) (undelayed)
//   vga_hs       out  horizontal sync, active low, PIPE_DELAY clocks late
//   vga_vs       out  vertical sync, active low, PIPE_DELAY clocks late
//   vga_blank_n  out  low outside the visible area, PIPE_DELAY clocks late
//   frame_count  out  [15:0] completed-frame counter
//
// Build option:
//   VGA_TIMING_FRAME_CNT_EN  when defined, frame_count is a 16-bit wrapping
//                            counter of completed frames; otherwise it is
//                            tied to zero and no register is built.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        active,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Decode boundaries are kept 11 bits wide so a total of exactly 1024
    // still compares correctly against the 10-bit counters.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
        end
    endgenerate

    // One delay-stage entry: the three strobes travel together.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    sync_t       r_pipe [PIPE_DELAY];

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_h_wrap;
    logic        w_v_last;
    sync_t       w_raw;

    assign w_h      = {1'b0, r_hcount};
    assign w_v      = {1'b0, r_vcount};
    assign w_h_wrap = (w_h == H_LAST);
    assign w_v_last = (w_v == V_LAST);

    // ---------------- raster counters ----------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_h_wrap) begin
            r_hcount <= '0;
            r_vcount <= w_v_last ? 10'd0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 10'd1;
        end
    end

    // ---------------- undelayed decodes ----------------
    assign active      = (w_h < H_VIS_END) && (w_v < V_VIS_END);
    assign frame_start = (r_hcount == 10'd0) && (r_vcount == 10'd0);

    assign w_raw.hs      = !((w_h >= HS_START) && (w_h < HS_END));
    assign w_raw.vs      = !((w_v >= VS_START) && (w_v < VS_END));
    assign w_raw.blank_n = active;

    // ---------------- sync/blank delay line ----------------
    // Stage 0 captures the raw decode; the last stage drives the pins.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= SYNC_IDLE;
            end
        end else begin
            r_pipe[0] <= w_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign vga_hs      = r_pipe[PIPE_DELAY-1].hs;
    assign vga_vs      = r_pipe[PIPE_DELAY-1].vs;
    assign vga_blank_n = r_pipe[PIPE_DELAY-1].blank_n;

    // ---------------- completed-frame counter ----------------
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (w_h_wrap && w_v_last) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 16'h0000;
`endif

endmodule
